// File: rtl/joybus_pkg.sv
// Shared types and line-encoding constants for the joybus poller.
// Combinational helpers only; no latency and no flow control.
package joybus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_STOP,
        ST_WAIT_RESP,
        ST_RX,
        ST_DONE
    } state_t;

    // line_oe level per quarter, quarter 0 in the MSB
    localparam logic [3:0]  ENC_ZERO = 4'b1110;
    localparam logic [3:0]  ENC_ONE  = 4'b1000;
    localparam logic [23:0] POLL_CMD = 24'h400300;

    function automatic logic enc_level(input logic bit_val, input logic [1:0] quarter);
        logic [3:0] pat;
        pat = bit_val ? ENC_ONE : ENC_ZERO;
        return pat[2'd3 - quarter];
    endfunction

endpackage

// File: rtl/joybus_line_sync.sv
// Two-flop synchroniser for the raw pad level plus a falling-edge strobe.
// Latency: 2 clk to line_s, fall asserted with the first low line_s; no backpressure.
module joybus_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic line_in,
    output logic line_s,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= line_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign line_s = sync2;
    assign fall   = prev & ~sync2;

endmodule

// File: rtl/joybus_poller.sv
// Single-wire open-drain poller: quarter-bit command TX, mid-bit sampled RX, one-shot/auto poll.
// Latency: line_oe rises the cycle after launch; no backpressure, start while busy is dropped.
module joybus_poller
    import joybus_pkg::*;
#(
    parameter int QUARTER_CYC = 50,
    parameter int CMD_BITS    = 24,
    parameter int RESP_BITS   = 64,
    parameter int POLL_PERIOD = 300000,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [CMD_BITS-1:0]  cmd,
    input  logic                 start,
    input  logic                 auto_en,
    input  logic                 line_in,
    output logic                 line_oe,
    output logic                 busy,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 resp_valid,
    output logic                 timeout_err
);

    localparam int QW      = (QUARTER_CYC > 1) ? $clog2(QUARTER_CYC) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYC > 6*QUARTER_CYC) ? TIMEOUT_CYC : 6*QUARTER_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(POLL_PERIOD);
    localparam int BW      = $clog2(CMD_BITS + 1);
    localparam int RBW     = $clog2(RESP_BITS + 1);

    state_t               state, state_nxt;
    logic [QW-1:0]        qcnt;
    logic [1:0]           qidx;
    logic [BW-1:0]        bidx;
    logic [CMD_BITS-1:0]  tx_sr;
    logic [RESP_BITS-1:0] rx_sr;
    logic [RESP_BITS-1:0] rx_shift;
    logic [RBW-1:0]       rbits;
    logic [CW-1:0]        cnt;
    logic [PW-1:0]        tmr;
    logic                 sampled;
    logic                 line_s, fall;
    logic                 launch, do_sample, rx_last, abort, q_end, bit_end;

    joybus_line_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .line_in (line_in),
        .line_s  (line_s),
        .fall    (fall)
    );

    assign busy     = (state != ST_IDLE);
    assign rx_shift = {rx_sr[RESP_BITS-2:0], line_s};
    assign q_end    = (qcnt == QW'(QUARTER_CYC - 1));
    assign bit_end  = q_end && (qidx == 2'd3);

    // line_oe decodes from async-reset state, so reset releases the line without a clock
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        do_sample = 1'b0;
        rx_last   = 1'b0;
        abort     = 1'b0;
        line_oe   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start || (auto_en && tmr == PW'(POLL_PERIOD - 1))) begin
                    launch    = 1'b1;
                    state_nxt = ST_TX;
                end
            end
            ST_TX: begin
                line_oe = enc_level(tx_sr[CMD_BITS-1], qidx);
                if (bit_end && bidx == BW'(CMD_BITS - 1))
                    state_nxt = ST_STOP;
            end
            ST_STOP: begin
                line_oe = enc_level(1'b1, qidx);
                if (bit_end)
                    state_nxt = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (fall)
                    state_nxt = ST_RX;
                else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_RX: begin
                // cnt is cycles since the bit's falling edge; edges before the sample are glitches
                if (!sampled) begin
                    if (cnt == CW'(2*QUARTER_CYC)) begin
                        do_sample = 1'b1;
                        if (rbits == RBW'(RESP_BITS - 1)) begin
                            rx_last   = 1'b1;
                            state_nxt = ST_DONE;
                        end
                    end
                end else if (!fall && cnt == CW'(6*QUARTER_CYC - 1)) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (line_s && cnt == CW'(4*QUARTER_CYC - 1))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            qcnt        <= '0;
            qidx        <= '0;
            bidx        <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            rbits       <= '0;
            cnt         <= '0;
            tmr         <= '0;
            sampled     <= 1'b0;
            resp_data   <= '0;
            resp_valid  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            resp_valid  <= 1'b0;
            timeout_err <= abort;
            // saturates while busy so an overdue auto poll launches as soon as IDLE is reached
            if (!auto_en || launch)
                tmr <= '0;
            else if (tmr != PW'(POLL_PERIOD - 1))
                tmr <= tmr + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        tx_sr <= cmd;
                        bidx  <= '0;
                        qcnt  <= '0;
                        qidx  <= '0;
                    end
                end
                ST_TX, ST_STOP: begin
                    if (q_end) begin
                        qcnt <= '0;
                        qidx <= qidx + 1'b1;
                    end else begin
                        qcnt <= qcnt + 1'b1;
                    end
                    if (bit_end) begin
                        tx_sr <= tx_sr << 1;
                        bidx  <= bidx + 1'b1;
                    end
                    cnt <= '0;
                end
                ST_WAIT_RESP: begin
                    if (fall) begin
                        cnt     <= CW'(1);
                        sampled <= 1'b0;
                        rbits   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RX: begin
                    if (do_sample) begin
                        rx_sr   <= rx_shift;
                        rbits   <= rbits + 1'b1;
                        sampled <= 1'b1;
                        cnt     <= cnt + 1'b1;
                        if (rx_last) begin
                            resp_data  <= rx_shift;
                            resp_valid <= 1'b1;
                            cnt        <= '0;
                        end
                    end else if (sampled && fall) begin
                        cnt     <= CW'(1);
                        sampled <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: cnt <= line_s ? cnt + 1'b1 : '0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/joybus_poller.md
Name: joybus_poller

Overview:
Parametrised single-wire open-drain controller poller for GameCube-style peripherals (bongos, pads).
- Serialises a programmable command with quarter-bit encoding, plus a stop bit.
- Receives a fixed-length response by mid-bit sampling and reports it with a valid strobe.
- Supports one-shot and periodic auto-poll, with response and inter-bit timeouts.
- Sits between the board-level tristate buffer and the input-decode / display logic.

Parameters:
- QUARTER_CYC, 50: clk cycles per quarter bit (one bit = 4 quarters); minimum 4.
- CMD_BITS, 24: command length in bits, sent MSB first.
- RESP_BITS, 64: response length in bits, received MSB first.
- POLL_PERIOD, 300000: clk cycles between auto-poll launches.
- TIMEOUT_CYC, 1000: maximum idle-line cycles while awaiting a response falling edge.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd  in  CMD_BITS  command word; latched when a poll launches
- start  in  1  one-cycle request for a single poll
- auto_en  in  1  when 1, launch a poll every POLL_PERIOD cycles
- line_in  in  1  raw pad level; asynchronous to clk
- line_oe  out  1  1 = drive line low, 0 = release (pull-up)
- busy  out  1  high in every state except IDLE
- resp_data  out  RESP_BITS  last complete response
- resp_valid  out  1  one-cycle pulse when resp_data updates
- timeout_err  out  1  one-cycle pulse when a poll is aborted

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on reset_n. On assertion:
  - line_oe=0, busy=0, resp_valid=0, timeout_err=0, resp_data=0.
  - All counters return to 0 and the FSM returns to IDLE.
  - line_oe must fall within the reset assertion itself, not at a clock edge. Reset mid-TX therefore releases the line immediately.
- line_in handling: passes through a 2-flop synchroniser, then a falling-edge detector (prev=1, cur=0).
- Quarter tick: a counter wraps at QUARTER_CYC-1. It restarts at 0 on entry to TX and on every RX falling-edge detect.
- Bit encoding (TX):
  - Bit 0: line_oe=1 for quarters 0-2, 0 for quarter 3.
  - Bit 1: line_oe=1 for quarter 0, 0 for quarters 1-3.
  - Stop bit: encoded as bit 1.
- FSM states: IDLE, TX, STOP, WAIT_RESP, RX, DONE.
- IDLE:
  - Launch when start=1, or when auto_en=1 and the poll timer reaches POLL_PERIOD-1.
  - On launch: latch cmd into the shift register, set bit index to 0, go to TX. line_oe rises on the cycle after launch.
  - start while busy=1 is ignored (not queued).
  - The poll timer runs only while auto_en=1 and resets to 0 on every launch. With auto_en=0 it holds 0.
  - If start and a timer launch coincide, only one poll is launched.
- TX: send CMD_BITS bits, 4*QUARTER_CYC cycles each. After bit CMD_BITS-1, go to STOP.
- STOP: send one stop bit, then go to WAIT_RESP with the timeout counter at 0. Total TX+STOP time is (CMD_BITS+1)*4*QUARTER_CYC cycles.
- WAIT_RESP:
  - line_oe=0 throughout.
  - A falling edge moves to RX and counts as the start of response bit 0.
  - If the counter reaches TIMEOUT_CYC with no edge: pulse timeout_err, go to IDLE.
- RX:
  - Sample the synchronised line exactly 2*QUARTER_CYC cycles after each falling-edge detect.
  - Shift the sample into a RESP_BITS shift register, MSB first.
  - After a sample, if no next falling edge arrives within 4*QUARTER_CYC cycles and the bit count is below RESP_BITS: pulse timeout_err, leave resp_data unchanged, go to IDLE.
  - After RESP_BITS samples, go to DONE. The device stop bit is ignored.
- DONE:
  - Copy the shift register to resp_data and pulse resp_valid, both in the same cycle.
  - Stay in DONE until the synchronised line has been high for 4*QUARTER_CYC consecutive cycles, so the device stop bit is swallowed, then go to IDLE.
- Truncated responses never update resp_data.
- A change to cmd during a poll has no effect until the next launch.
- auto_en deasserted mid-poll lets the current poll complete.

Decomposition:
- joybus_pkg:
  - FSM state enum.
  - Quarter-pattern constants: ENC_ZERO=4'b1110 and ENC_ONE=4'b1000, as line_oe per quarter with quarter 0 as the MSB.
  - Default command constant POLL_CMD=24'h400300.
- Sub-module joybus_line_sync: 2-flop synchroniser plus falling-edge detect.
  - Inputs: clk, reset_n, line_in.
  - Outputs: line_s, fall.
  - Reset value of both flops is 1 (idle high).

Test Plan:
- QUARTER_CYC=4, cmd=24'h400302, start pulse → line_oe pattern:
  - bit 23 (=0): high 12 / low 4.
  - bit 22 (=1): high 4 / low 12.
  - TX+STOP span of 400 cycles, then line_oe=0.
- Device model answers 64 bits 0xA5C3_0000_0000_00FF (bit 1 = low 4 / high 12, bit 0 = low 12 / high 4), plus stop → resp_valid pulses once with resp_data=64'hA5C3_0000_0000_00FF; busy falls after the stop bit.
- No device response, TIMEOUT_CYC=1000 → timeout_err pulses exactly 1000 cycles after WAIT_RESP entry; resp_data keeps its previous value; busy=0.
- Device stops after 40 bits → timeout_err 16 cycles after the 40th sample point; no resp_valid; resp_data unchanged.
- auto_en=1, POLL_PERIOD=2000 → launches (line_oe rising) 2000 cycles apart; start pulses issued while busy produce no extra poll.
- reset_n dropped mid-TX while line_oe=1 → line_oe=0 before the next clk edge; after release, FSM in IDLE, outputs at reset values, and the next start yields a clean full poll.
